// File: rtl/vnu_serial.sv
// -----------------------------------------------------------------------------
// vnu_serial -- serial Variable Node Unit for the LDPC decoder.
//
// Takes one channel LLR and DV check-to-variable (C2V) messages per variable
// node, one per cycle over a valid/ready handshake. It returns DV extrinsic
// variable-to-check (V2C) messages and a hard-decision bit. Each V2C message
// is the node total minus that slot's own C2V, saturated to the V2C range.
// All message formats are sign-magnitude. Internal arithmetic is two's
// complement.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         begin a node (accepted only while idle)
//   llr_in        channel LLR, VW-bit sign-magnitude, sampled with start
//   idle          high while waiting for start
//   c2v_valid/c2v_ready/c2v_data   C2V input beats (CW-bit sign-magnitude)
//   v2c_valid/v2c_ready/v2c_data   V2C output beats (VW-bit sign-magnitude)
//   v2c_idx       index of the current V2C beat (C2V arrival order)
//   hard_bit      1 when the last completed node total was negative
//   done          one-cycle pulse after the final V2C handshake
//   sat_cnt       (VNU_SAT_CNT_EN only) count of clamped V2C beats in the
//                 current node, saturating at 255
//
// Optional feature macro: VNU_SAT_CNT_EN
// -----------------------------------------------------------------------------
module vnu_serial #(
  parameter int DV = 3,
  parameter int CW = 5,
  parameter int VW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [VW-1:0] llr_in,
  output logic          idle,
  input  logic          c2v_valid,
  output logic          c2v_ready,
  input  logic [CW-1:0] c2v_data,
  output logic          v2c_valid,
  input  logic          v2c_ready,
  output logic [VW-1:0] v2c_data,
  output logic [$clog2(DV)-1:0] v2c_idx,
  output logic          hard_bit,
  output logic          done
`ifdef VNU_SAT_CNT_EN
  ,
  output logic [7:0]    sat_cnt
`endif
);

  localparam int IW      = $clog2(DV);
  // Largest possible node total magnitude. It is used to size the accumulator
  // so that it cannot wrap.
  localparam int MAX_SUM = (2**(VW-1) - 1) + DV * (2**(CW-1) - 1);
  localparam int AW      = $clog2(MAX_SUM + 1) + 1;

  localparam logic signed [AW-1:0] VMAX_S  = AW'(2**(VW-1) - 1);
  localparam logic        [VW-2:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_SEND
  } state_t;

  state_t               state;
  logic [IW-1:0]        cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] slot [DV];
`ifdef VNU_SAT_CNT_EN
  logic                 v2c_clamped;
`endif

  // Combinational datapath
  logic signed [AW-1:0] c2v_mag, c2v_tc;
  logic signed [AW-1:0] llr_mag, llr_tc;
  logic signed [AW-1:0] sum_last;
  logic signed [AW-1:0] ext, ext_abs;
  logic                 cnt_last;
  logic [IW-1:0]        cnt_next;
  logic                 sat_clamped;
  logic [VW-1:0]        sat_data;

  // NOTE: every always_comb output is given a default first, so that no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    c2v_mag     = AW'(c2v_data[CW-2:0]);
    llr_mag     = AW'(llr_in[VW-2:0]);
    // A negative zero in sign-magnitude negates to 0, so it needs no special case.
    c2v_tc      = c2v_data[CW-1] ? -c2v_mag : c2v_mag;
    llr_tc      = llr_in[VW-1]   ? -llr_mag : llr_mag;
    sum_last    = acc + c2v_tc;
    cnt_last    = (cnt == IW'(DV - 1));
    cnt_next    = cnt_last ? '0 : cnt + IW'(1);

    // Operand for the next V2C beat to be registered. When the final C2V
    // arrives, the total is still in flight (sum_last) and beat 0 comes next.
    // In SEND, the accumulator holds the final total.
    if (state == S_RECV) ext = sum_last - slot[0];
    else                 ext = acc - slot[cnt_next];

    ext_abs     = ext[AW-1] ? -ext : ext;
    sat_clamped = (ext_abs > VMAX_S);
    // The sign comes straight from the two's-complement value, so zero is
    // always encoded with sign 0.
    sat_data    = sat_clamped ? {ext[AW-1], MAG_MAX}
                              : {ext[AW-1], ext_abs[VW-2:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idle      <= 1'b1;
      c2v_ready <= 1'b0;
      v2c_valid <= 1'b0;
      v2c_data  <= '0;
      v2c_idx   <= '0;
      hard_bit  <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      // NOTE: the message store is a small register file and is cleared on
      // reset. Larger memories would normally be left unreset.
      for (int i = 0; i < DV; i++) slot[i] <= '0;
`ifdef VNU_SAT_CNT_EN
      sat_cnt     <= '0;
      v2c_clamped <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc       <= llr_tc;
            cnt       <= '0;
            state     <= S_RECV;
            idle      <= 1'b0;
            c2v_ready <= 1'b1;
`ifdef VNU_SAT_CNT_EN
            sat_cnt   <= '0;
`endif
          end
        end

        S_RECV: begin
          if (c2v_valid) begin
            slot[cnt] <= c2v_tc;
            acc       <= sum_last;
            if (cnt_last) begin
              cnt       <= '0;
              state     <= S_SEND;
              c2v_ready <= 1'b0;
              v2c_valid <= 1'b1;
              v2c_idx   <= '0;
              v2c_data  <= sat_data;
              hard_bit  <= sum_last[AW-1];
`ifdef VNU_SAT_CNT_EN
              v2c_clamped <= sat_clamped;
`endif
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end

        S_SEND: begin
          if (v2c_ready) begin
`ifdef VNU_SAT_CNT_EN
            if (v2c_clamped && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
`endif
            if (cnt_last) begin
              cnt       <= '0;
              state     <= S_IDLE;
              idle      <= 1'b1;
              v2c_valid <= 1'b0;
              v2c_idx   <= '0;
              v2c_data  <= '0;
              done      <= 1'b1;
            end else begin
              cnt      <= cnt_next;
              v2c_idx  <= cnt_next;
              v2c_data <= sat_data;
`ifdef VNU_SAT_CNT_EN
              v2c_clamped <= sat_clamped;
`endif
            end
          end
        end

        default: begin
          state <= S_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vnu_serial.sv
// -----------------------------------------------------------------------------
// tb_vnu_serial -- self-checking bench for vnu_serial (DV=3, CW=5, VW=6).
// The expected values come from an integer model of the node rules:
// total = LLR + sum(C2V), V2C_i = sat(total - C2V_i), hard = total < 0.
// -----------------------------------------------------------------------------
module tb_vnu_serial;

  localparam int DV   = 3;
  localparam int CW   = 5;
  localparam int VW   = 6;
  localparam int IW   = $clog2(DV);
  localparam int VMAX = 2**(VW-1) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] llr_in = '0;
  logic          idle;
  logic          c2v_valid = 1'b0;
  logic          c2v_ready;
  logic [CW-1:0] c2v_data = '0;
  logic          v2c_valid;
  logic          v2c_ready = 1'b0;
  logic [VW-1:0] v2c_data;
  logic [IW-1:0] v2c_idx;
  logic          hard_bit;
  logic          done;
`ifdef VNU_SAT_CNT_EN
  logic [7:0]    sat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vnu_serial #(.DV(DV), .CW(CW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .llr_in    (llr_in),
    .idle      (idle),
    .c2v_valid (c2v_valid),
    .c2v_ready (c2v_ready),
    .c2v_data  (c2v_data),
    .v2c_valid (v2c_valid),
    .v2c_ready (v2c_ready),
    .v2c_data  (v2c_data),
    .v2c_idx   (v2c_idx),
    .hard_bit  (hard_bit),
    .done      (done)
`ifdef VNU_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each step advances to just after the next rising edge, so that both
  // driving and sampling happen away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int sm2i(input logic [7:0] v, input int w);
    int mag;
    mag = int'(v) & ((1 << (w - 1)) - 1);
    return v[w-1] ? -mag : mag;
  endfunction

  function automatic logic [VW-1:0] i2sm(input int x);
    int c;
    c = (x > VMAX) ? VMAX : ((x < -VMAX) ? -VMAX : x);
    if (c < 0) return {1'b1, (VW-1)'(-c)};
    return {1'b0, (VW-1)'(c)};
  endfunction

  // Runs one node. c2v_pk holds beat i in bits [i*CW +: CW]. gap is the
  // number of idle cycles before each beat after the first. stall_cyc holds
  // v2c_ready low on beat stall_idx. poke pulses start during RECV and SEND.
  task automatic run_node(input string name, input logic [VW-1:0] llr,
                          input logic [DV*CW-1:0] c2v_pk, input int gap,
                          input int stall_idx, input int stall_cyc, input bit poke);
    int total, ext, nclamp, edges, exp_lat, k;
    logic [VW-1:0] exp_v2c [DV];
    logic          exp_hard;

    total  = sm2i(8'(llr), VW);
    for (int i = 0; i < DV; i++) total += sm2i(8'(c2v_pk[i*CW +: CW]), CW);
    nclamp = 0;
    for (int i = 0; i < DV; i++) begin
      ext = total - sm2i(8'(c2v_pk[i*CW +: CW]), CW);
      exp_v2c[i] = i2sm(ext);
      if (ext > VMAX || ext < -VMAX) nclamp++;
    end
    exp_hard = (total < 0);
    exp_lat  = 2 * DV + (DV - 1) * gap + ((stall_idx < DV) ? stall_cyc : 0);

    k = 0;
    while (idle !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    check({name, ":idle_before"}, 32'(idle), 32'd1);

    start  = 1'b1;
    llr_in = llr;
    step();
    start  = 1'b0;
    llr_in = VW'($urandom);
    edges  = 0;
    check({name, ":c2v_ready"}, 32'(c2v_ready), 32'd1);
    check({name, ":idle_recv"}, 32'(idle), 32'd0);
`ifdef VNU_SAT_CNT_EN
    check({name, ":sat_cnt_clr"}, 32'(sat_cnt), 32'd0);
`endif

    for (int i = 0; i < DV; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          c2v_valid = 1'b0;
          c2v_data  = CW'($urandom);
          start     = poke;
          step();
          start     = 1'b0;
          edges++;
          check({name, ":gap_ready"}, 32'(c2v_ready), 32'd1);
        end
      end
      c2v_valid = 1'b1;
      c2v_data  = c2v_pk[i*CW +: CW];
      start     = poke && (i == 1);
      step();
      start     = 1'b0;
      edges++;
      c2v_valid = 1'b0;
      c2v_data  = CW'($urandom);
    end

    check({name, ":hard_bit"}, 32'(hard_bit), 32'(exp_hard));
    check({name, ":c2v_ready_off"}, 32'(c2v_ready), 32'd0);

    for (int j = 0; j < DV; j++) begin
      check({name, ":v2c_valid"}, 32'(v2c_valid), 32'd1);
      check({name, ":v2c_idx"}, 32'(v2c_idx), 32'(j));
      check({name, ":v2c_data"}, 32'(v2c_data), 32'(exp_v2c[j]));
      if (j == stall_idx) begin
        for (int s = 0; s < stall_cyc; s++) begin
          v2c_ready = 1'b0;
          step();
          edges++;
          check({name, ":stall_valid"}, 32'(v2c_valid), 32'd1);
          check({name, ":stall_idx"}, 32'(v2c_idx), 32'(j));
          check({name, ":stall_data"}, 32'(v2c_data), 32'(exp_v2c[j]));
        end
      end
      v2c_ready = 1'b1;
      start     = poke && (j == 0);
      step();
      start     = 1'b0;
      v2c_ready = 1'b0;
      edges++;
      if (j < DV - 1) check({name, ":no_early_done"}, 32'(done), 32'd0);
    end

    check({name, ":done"}, 32'(done), 32'd1);
    check({name, ":idle_done"}, 32'(idle), 32'd1);
    check({name, ":v2c_valid_off"}, 32'(v2c_valid), 32'd0);
    check({name, ":latency"}, 32'(edges), 32'(exp_lat));
`ifdef VNU_SAT_CNT_EN
    check({name, ":sat_cnt"}, 32'(sat_cnt), 32'(nclamp));
`endif
    step();
    check({name, ":done_pulse"}, 32'(done), 32'd0);
    check({name, ":hard_hold"}, 32'(hard_bit), 32'(exp_hard));
    check({name, ":stay_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    logic [VW-1:0]    r_llr;
    logic [DV*CW-1:0] r_c2v;

    rst_n = 1'b0;
    step();
    step();
    check("rst:idle", 32'(idle), 32'd1);
    check("rst:c2v_ready", 32'(c2v_ready), 32'd0);
    check("rst:v2c_valid", 32'(v2c_valid), 32'd0);
    check("rst:v2c_data", 32'(v2c_data), 32'd0);
    check("rst:v2c_idx", 32'(v2c_idx), 32'd0);
    check("rst:hard_bit", 32'(hard_bit), 32'd0);
    check("rst:done", 32'(done), 32'd0);
`ifdef VNU_SAT_CNT_EN
    check("rst:sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Basic node: total +7, V2C +4 +9 +6.
    run_node("basic", 6'b000101, {5'b00001, 5'b10010, 5'b00011}, 0, DV, 0, 1'b0);
    // Positive and negative saturation.
    run_node("sat_pos", 6'b011111, {5'b01111, 5'b01111, 5'b01111}, 0, DV, 0, 1'b0);
    run_node("sat_neg", 6'b111111, {5'b11111, 5'b11111, 5'b11111}, 0, DV, 0, 1'b0);
    // Zero and negative zero: V2C -2 +2 0.
    run_node("zero", 6'b100000, {5'b10000, 5'b10010, 5'b00010}, 0, DV, 0, 1'b0);
    // Handshake stalls on both sides.
    run_node("stall", 6'b000101, {5'b00001, 5'b10010, 5'b00011}, 2, 1, 3, 1'b0);
    // start pulses while busy are ignored.
    run_node("poke", 6'b000101, {5'b00001, 5'b10010, 5'b00011}, 1, DV, 0, 1'b1);

    // Reset during SEND at idx 1, with a negative node so that hard_bit is set.
    start  = 1'b1;
    llr_in = 6'b100101;
    step();
    start  = 1'b0;
    for (int i = 0; i < DV; i++) begin
      c2v_valid = 1'b1;
      c2v_data  = (i == 0) ? 5'b10011 : ((i == 1) ? 5'b00010 : 5'b10001);
      step();
    end
    c2v_valid = 1'b0;
    v2c_ready = 1'b1;
    step();
    v2c_ready = 1'b0;
    check("mrst:pre_idx", 32'(v2c_idx), 32'd1);
    check("mrst:pre_hard", 32'(hard_bit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst:idle", 32'(idle), 32'd1);
    check("mrst:v2c_valid", 32'(v2c_valid), 32'd0);
    check("mrst:hard_bit", 32'(hard_bit), 32'd0);
    check("mrst:done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst:no_done", 32'(done), 32'd0);
      check("mrst:still_idle", 32'(idle), 32'd1);
    end
    run_node("post_rst", 6'b000101, {5'b00001, 5'b10010, 5'b00011}, 0, DV, 0, 1'b0);

    // Randomized nodes.
    for (int n = 0; n < 30; n++) begin
      r_llr = VW'($urandom);
      r_c2v = (DV*CW)'($urandom);
      run_node("rand", r_llr, r_c2v, int'($urandom_range(0, 2)),
               int'($urandom_range(0, DV)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
